shift_rows_pipe: RTL and testbench

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/shift_rows_pipe_pkg.sv | 20 ++
 rtl/shift_rows_perm.sv | 19 +
 rtl/shift_rows_pipe.sv | 64 ++++++
 tb/tb_shift_rows_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_rows_pipe_pkg.sv
// shift_rows_pipe_pkg: row offsets, byte indexing and legal sizes for the ShiftRows pipeline
package shift_rows_pipe_pkg;
  localparam int NB_MIN = 4;
  localparam int NB_MAX = 8;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  function automatic bit nb_legal(int nb);
    return nb == 4 || nb == 6 || nb == 8;
  endfunction
  function automatic bit stages_legal(int stages);
    return stages >= STAGES_MIN && stages <= STAGES_MAX;
  endfunction
  // Rijndael with 8 columns shifts rows 2 and 3 one further than the narrower states
  function automatic int row_off(int nb, int r);
    return (nb == 8 && r > 1) ? r + 1 : r;
  endfunction
  function automatic int byte_idx(int r, int c);
    return 4 * c + r;
  endfunction
endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows / InvShiftRows byte permutation
module shift_rows_perm
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic             inv,
  input  logic [0:32*NB-1] in_data,
  output logic [0:32*NB-1] out_data
);
  for (genvar c = 0; c < NB; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      localparam int FWD = (c + row_off(NB, r)) % NB;
      localparam int BWD = (c - row_off(NB, r) + NB) % NB;
      assign out_data[8*byte_idx(r, c) +: 8] = inv ? in_data[8*byte_idx(r, BWD) +: 8]
                                                   : in_data[8*byte_idx(r, FWD) +: 8];
    end
  end
endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: ShiftRows permutation followed by an elastic valid/ready register pipeline
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_inv,
  input  logic [0:32*NB-1]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:32*NB-1]             out_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);
  localparam int W  = 32 * NB;
  localparam int OW = $clog2(STAGES + 1);
  if (!nb_legal(NB) || !stages_legal(STAGES)) begin : g_bad
    $error("shift_rows_pipe: illegal NB=%0d or STAGES=%0d", NB, STAGES);
  end
  logic [0:W-1]        perm_data;
  logic [0:W-1]        data_q [STAGES];
  logic [STAGES-1:0]   valid_q, valid_d, rdy;
  logic [STAGES:0]     vsrc;
  logic [OW-1:0]       occ_q, occ_d;
  logic                acc, emit;
  shift_rows_perm #(.NB(NB)) u_perm (
    .inv      (in_inv),
    .in_data  (in_data),
    .out_data (perm_data)
  );
  assign vsrc = {valid_q, in_valid};
  // stage k can load unless it and every stage after it is full and the output is stalled
  always_comb begin
    rdy = '0;
    for (int k = 0; k < STAGES; k++)
      rdy[k] = out_ready || !(&(valid_q | STAGES'((1 << k) - 1)));
    valid_d = (rdy & vsrc[STAGES-1:0]) | (~rdy & valid_q);
    acc = in_valid && rdy[0];
    emit = valid_q[STAGES-1] && out_ready;
    occ_d = occ_q + OW'(acc) - OW'(emit);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      occ_q <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) data_q[0] <= perm_data;
    for (int k = 1; k < STAGES; k++)
      if (rdy[k] && valid_q[k-1]) data_q[k] <= data_q[k-1];
  end
  assign in_ready = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data = data_q[STAGES-1];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: scoreboard bench for NB=4/STAGES=3 and NB=8/STAGES=2 pipelines
module tb_shift_rows_pipe;
  logic clk = 1'b0;
  logic reset;
  logic in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
  logic [0:127] in_data4, out_data4;
  logic [1:0] occupancy4;
  logic in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [0:255] in_data8, out_data8;
  logic [1:0] occupancy8;
  int total = 0;
  int bad = 0;
  logic [0:127] q4[$];
  logic [0:255] q8[$];
  logic [0:255] got8[$];
  logic prev_stall4 = 1'b0;
  logic [0:127] prev_data4;
  logic seen_full = 1'b0;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .STAGES(3)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .occupancy(occupancy4)
  );
  shift_rows_pipe #(.NB(8), .STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .occupancy(occupancy8)
  );

  task automatic chk(input string tag, input logic [0:255] obs, input logic [0:255] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:255] perm_model(input logic [0:255] d, input int nb, input logic inv);
    int o4[4] = '{0, 1, 2, 3};
    int o8[4] = '{0, 1, 3, 4};
    logic [0:255] res = '0;
    int o, s;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        o = (nb == 8) ? o8[r] : o4[r];
        s = inv ? (c - o + nb) % nb : (c + o) % nb;
        res[8*(4*c+r) +: 8] = d[8*(4*s+r) +: 8];
      end
    return res;
  endfunction

  function automatic logic [0:127] m4(input logic [0:127] d, input logic inv);
    logic [0:255] t = perm_model({d, 128'h0}, 4, inv);
    return t[0:127];
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [0:127] d, input logic inv, input logic [0:127] e);
    int n = 0;
    q4.push_back(e);
    in_valid4 = 1'b1; in_data4 = d; in_inv4 = inv;
    @(negedge clk);
    while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
    chk("send4_accept", in_ready4, 1'b1);
    sync();
    in_valid4 = 1'b0;
  endtask

  task automatic send8(input logic [0:255] d, input logic inv, input logic [0:255] e);
    int n = 0;
    q8.push_back(e);
    in_valid8 = 1'b1; in_data8 = d; in_inv8 = inv;
    @(negedge clk);
    while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
    chk("send8_accept", in_ready8, 1'b1);
    sync();
    in_valid8 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 300) begin @(negedge clk); n++; end
    chk("drain", q4.size() + q8.size(), 0);
    sync();
  endtask

  always @(negedge clk) begin
    logic [0:127] e;
    if (!reset) prev_stall4 = 1'b0;
    else begin
      if (prev_stall4) begin
        chk("stall_valid4", out_valid4, 1'b1);
        chk("stall_data4", out_data4, prev_data4);
      end
      chk("occ_max4", occupancy4 <= 2'd3, 1'b1);
      if (occupancy4 == 2'd3 && !out_ready4) begin
        seen_full = 1'b1;
        chk("full_in_ready4", in_ready4, 1'b0);
      end
      if (out_valid4 && out_ready4) begin
        chk("q4_has_beat", q4.size() > 0, 1'b1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          chk("out4", out_data4, e);
        end
      end
      prev_stall4 = out_valid4 && !out_ready4;
      prev_data4 = out_data4;
    end
  end

  always @(negedge clk) begin
    logic [0:255] e;
    if (reset && out_valid8 && out_ready8) begin
      chk("q8_has_beat", q8.size() > 0, 1'b1);
      chk("occ_max8", occupancy8 <= 2'd2, 1'b1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        got8.push_back(out_data8);
        chk("out8", out_data8, e);
      end
    end
  end

  initial begin
    logic [0:127] fips_in, fips_out, d;
    logic [0:255] ramp, f;
    logic [7:0] row2 [8];
    row2 = '{8'h0e, 8'h12, 8'h16, 8'h1a, 8'h1e, 8'h02, 8'h06, 8'h0a};
    fips_in = 128'hd42711aee0bf98f1b8b45de51e415230;
    fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    for (int k = 0; k < 32; k++) ramp[8*k +: 8] = 8'(k);
    reset = 1'b0;
    in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    #3;
    chk("rst_out_valid4", out_valid4, 1'b0);
    chk("rst_occ4", occupancy4, 2'd0);
    chk("rst_out_valid8", out_valid8, 1'b0);
    chk("rst_occ8", occupancy8, 2'd0);
    sync();
    reset = 1'b1;
    #2;
    chk("post_rst_in_ready4", in_ready4, 1'b1);
    chk("post_rst_in_ready8", in_ready8, 1'b1);
    // known-answer forward vector, with latency of three cycles
    send4(fips_in, 1'b0, fips_out);
    @(negedge clk); chk("lat_c1", out_valid4, 1'b0);
    @(negedge clk); chk("lat_c2", out_valid4, 1'b0);
    @(negedge clk); chk("lat_c3", out_valid4, 1'b1);
    sync();
    send4(fips_out, 1'b1, fips_in);
    wait_drain();
    // ten back-to-back beats with a four-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          d = {$urandom, $urandom, $urandom, $urandom};
          send4(d, i[0], m4(d, i[0]));
        end
      end
      begin
        repeat (4) sync();
        out_ready4 = 1'b0;
        repeat (4) sync();
        out_ready4 = 1'b1;
      end
    join
    wait_drain();
    chk("full_stall_seen", seen_full, 1'b1);
    // alternating mode at full rate
    for (int i = 0; i < 12; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send4(d, ~i[0], m4(d, ~i[0]));
    end
    wait_drain();
    // eight-column state: offsets 0,1,3,4
    send8(ramp, 1'b0, perm_model(ramp, 8, 1'b0));
    send8(perm_model(ramp, 8, 1'b0), 1'b1, ramp);
    wait_drain();
    chk("got8_count", got8.size(), 2);
    if (got8.size() > 0) begin
      f = got8.pop_front();
      for (int c = 0; c < 8; c++) chk("nb8_row2", f[8*(4*c+2) +: 8], row2[c]);
    end
    // reset with two beats in flight
    out_ready4 = 1'b0;
    send4(fips_in, 1'b0, fips_out);
    send4(fips_out, 1'b1, fips_in);
    sync();
    chk("pre_rst_occ4", occupancy4, 2'd2);
    chk("pre_rst_valid4", out_valid4, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid4", out_valid4, 1'b0);
    chk("async_rst_occ4", occupancy4, 2'd0);
    q4.delete();
    sync();
    reset = 1'b1;
    out_ready4 = 1'b1;
    repeat (10) sync();
    chk("no_stale_valid4", out_valid4, 1'b0);
    chk("no_stale_occ4", occupancy4, 2'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
